// File: rtl/cache_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cache_controller
//  Purpose  : Sequencing controller for a 4-way set-associative cache with a
//             write-through policy. Accepts single-word CPU requests, probes
//             the cache, services read misses from main memory, writes every
//             store through to memory and owns FIFO replacement per set.
//  Ports    : clk, reset_n            - clock, synchronous active-low reset
//             cpu_req/we/addr/wdata   - CPU request (accepted when cpu_ready)
//             cpu_ready/done/rdata/hit- CPU handshake and response
//             cache_read/write/address/write_data, cache_read_data/hit
//                                     - cache probe and update port
//             replace_way             - victim way (FIFO pointer of the set)
//             mem_req/we/addr/wdata, mem_ack/rdata
//                                     - main memory port, req held until ack
//             hit_count, miss_count   - only with CACHE_CTRL_STATS_EN defined
//  Options  : CACHE_CTRL_STATS_EN adds wrapping hit/miss counters.
//  Notes    : NUM_WAYS must be a power of two >= 2. Set index is addr[9:5]
//             for the default NUM_SETS.
//  Revision : 1.0 - initial release
// ============================================================================
module cache_controller #(
    parameter int NUM_SETS = 32,
    parameter int NUM_WAYS = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cpu_req,
    input  logic                        cpu_we,
    input  logic [31:0]                 cpu_addr,
    input  logic [31:0]                 cpu_wdata,
    output logic                        cpu_ready,
    output logic                        cpu_done,
    output logic [31:0]                 cpu_rdata,
    output logic                        cpu_hit,
    output logic                        cache_read,
    output logic                        cache_write,
    output logic [31:0]                 cache_address,
    output logic [31:0]                 cache_write_data,
    input  logic [31:0]                 cache_read_data,
    input  logic                        cache_hit,
    output logic [$clog2(NUM_WAYS)-1:0] replace_way,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [31:0]                 mem_addr,
    output logic [31:0]                 mem_wdata,
    input  logic                        mem_ack,
    input  logic [31:0]                 mem_rdata
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]                 hit_count,
    output logic [31:0]                 miss_count
`endif
);

    localparam int WAY_W = $clog2(NUM_WAYS);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MEM_RD = 3'd2,
        S_FILL   = 3'd3,
        S_MEM_WR = 3'd4,
        S_UPDATE = 3'd5,
        S_RESP   = 3'd6
    } state_t;

    state_t           state;
    logic [31:0]      req_addr;
    logic [31:0]      req_wdata;
    logic             req_we;
    logic             hit_q;
    logic [31:0]      rdata_q;
    logic [WAY_W-1:0] fifo_ptr [NUM_SETS];

    logic [IDX_W-1:0] index;
    logic [WAY_W-1:0] next_ptr;

    // Every downstream address/data comes from the request latches so the
    // CPU is free to change its inputs once the request has been taken.
    assign index         = req_addr[5 +: IDX_W];
    assign replace_way   = fifo_ptr[index];
    assign next_ptr      = (fifo_ptr[index] == LAST_WAY) ? '0 : fifo_ptr[index] + WAY_W'(1);
    assign cache_address = req_addr;
    assign mem_addr      = req_addr;
    assign mem_wdata     = req_wdata;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            req_addr         <= '0;
            req_wdata        <= '0;
            req_we           <= 1'b0;
            hit_q            <= 1'b0;
            rdata_q          <= '0;
            cpu_ready        <= 1'b1;
            cpu_done         <= 1'b0;
            cpu_rdata        <= '0;
            cpu_hit          <= 1'b0;
            cache_read       <= 1'b0;
            cache_write      <= 1'b0;
            cache_write_data <= '0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                fifo_ptr[s] <= '0;
            end
`ifdef CACHE_CTRL_STATS_EN
            hit_count        <= '0;
            miss_count       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (cpu_req) begin
                        req_addr   <= cpu_addr;
                        req_we     <= cpu_we;
                        req_wdata  <= cpu_wdata;
                        cpu_ready  <= 1'b0;
                        cache_read <= 1'b1;
                        state      <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    hit_q      <= cache_hit;
                    rdata_q    <= cache_read_data;
                    cache_read <= 1'b0;
                    if (req_we) begin
                        mem_req <= 1'b1;
                        mem_we  <= 1'b1;
                        state   <= S_MEM_WR;
                    end else if (cache_hit) begin
                        cpu_done  <= 1'b1;
                        cpu_rdata <= cache_read_data;
                        cpu_hit   <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        mem_req <= 1'b1;
                        state   <= S_MEM_RD;
                    end
                end
                S_MEM_RD: begin
                    if (mem_ack) begin
                        rdata_q          <= mem_rdata;
                        mem_req          <= 1'b0;
                        cache_write      <= 1'b1;
                        cache_write_data <= mem_rdata;
                        state            <= S_FILL;
                    end
                end
                S_FILL: begin
                    // The fill lands in replace_way this cycle; move on.
                    cache_write     <= 1'b0;
                    fifo_ptr[index] <= next_ptr;
                    cpu_done        <= 1'b1;
                    cpu_rdata       <= rdata_q;
                    cpu_hit         <= hit_q;
                    state           <= S_RESP;
                end
                S_MEM_WR: begin
                    if (mem_ack) begin
                        mem_req          <= 1'b0;
                        mem_we           <= 1'b0;
                        cache_write      <= 1'b1;
                        cache_write_data <= req_wdata;
                        state            <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    // A write miss allocates, so only then does the set's
                    // FIFO order move; a write hit updates in place.
                    cache_write <= 1'b0;
                    if (!hit_q) begin
                        fifo_ptr[index] <= next_ptr;
                    end
                    cpu_done  <= 1'b1;
                    cpu_rdata <= '0;
                    cpu_hit   <= hit_q;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    cpu_done  <= 1'b0;
                    cpu_rdata <= '0;
                    cpu_hit   <= 1'b0;
                    cpu_ready <= 1'b1;
                    state     <= S_IDLE;
`ifdef CACHE_CTRL_STATS_EN
                    if (hit_q) begin
                        hit_count <= hit_count + 32'd1;
                    end else begin
                        miss_count <= miss_count + 32'd1;
                    end
`endif
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cache_controller
//  Purpose  : Directed scoreboard bench for cache_controller. Contains a
//             behavioural 4-way cache, a main memory responder with
//             programmable wait, and monitors that check CPU responses,
//             cache writes and memory transactions against queued
//             expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_controller;

    localparam int PERIOD = 10;

    logic        clk;
    logic        reset_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_ready;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cpu_hit;
    logic        cache_read;
    logic        cache_write;
    logic [31:0] cache_address;
    logic [31:0] cache_write_data;
    logic [31:0] cache_read_data;
    logic        cache_hit;
    logic [1:0]  replace_way;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef CACHE_CTRL_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    cache_controller #(.NUM_SETS(32), .NUM_WAYS(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cpu_req          (cpu_req),
        .cpu_we           (cpu_we),
        .cpu_addr         (cpu_addr),
        .cpu_wdata        (cpu_wdata),
        .cpu_ready        (cpu_ready),
        .cpu_done         (cpu_done),
        .cpu_rdata        (cpu_rdata),
        .cpu_hit          (cpu_hit),
        .cache_read       (cache_read),
        .cache_write      (cache_write),
        .cache_address    (cache_address),
        .cache_write_data (cache_write_data),
        .cache_read_data  (cache_read_data),
        .cache_hit        (cache_hit),
        .replace_way      (replace_way),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .hit_count        (hit_count),
        .miss_count       (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #(PERIOD/2) clk = ~clk;

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    typedef struct { logic hit; logic [31:0] rdata; int lat; time t0; } sb_t;
    typedef struct { int way; logic [31:0] data; } wr_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } mem_t;

    sb_t  sb [$];
    wr_t  wq [$];
    mem_t mq [$];

    int vectors     = 0;
    int miscompares = 0;
    int mem_wait    = 1;
    int mem_txn     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural cache: tag = addr[31:10], index = addr[9:5]
    // ------------------------------------------------------------------
    logic [21:0] c_tag [32][4];
    logic        c_val [32][4];
    logic [31:0] c_dat [32][4];
    logic        m_hit;
    logic [1:0]  m_way;
    logic [31:0] m_data;

    always_comb begin
        m_hit  = 1'b0;
        m_way  = 2'd0;
        m_data = 32'd0;
        for (int w = 0; w < 4; w++) begin
            if (c_val[cache_address[9:5]][w] && c_tag[cache_address[9:5]][w] == cache_address[31:10]) begin
                m_hit  = 1'b1;
                m_way  = 2'(w);
                m_data = c_dat[cache_address[9:5]][w];
            end
        end
    end

    assign cache_hit       = cache_read & m_hit;
    assign cache_read_data = cache_read ? m_data : 32'd0;

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int s = 0; s < 32; s++) begin
                for (int w = 0; w < 4; w++) begin
                    c_val[s][w] <= 1'b0;
                end
            end
        end else if (cache_write) begin
            if (m_hit) begin
                c_dat[cache_address[9:5]][m_way] <= cache_write_data;
            end else begin
                c_val[cache_address[9:5]][replace_way] <= 1'b1;
                c_tag[cache_address[9:5]][replace_way] <= cache_address[31:10];
                c_dat[cache_address[9:5]][replace_way] <= cache_write_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Main memory responder: ack on the mem_wait-th cycle of mem_req
    // ------------------------------------------------------------------
    logic [31:0] mem_model [logic [31:0]];

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return {a[15:0], 16'hC0DE};
    endfunction

    initial begin
        int   mcnt;
        mem_t m;
        mcnt      = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 32'd0;
            if (mem_req) begin
                mcnt++;
                if (mcnt == 1) mem_txn++;
                if (mcnt >= mem_wait) begin
                    mem_ack = 1'b1;
                    mcnt    = 0;
                    if (mq.size() == 0) begin
                        check("unexpected_mem_access", 32'd1, 32'd0);
                    end else begin
                        m = mq.pop_front();
                        check("mem_we", 32'(mem_we), 32'(m.we));
                        check("mem_addr", mem_addr, m.addr);
                        if (m.we) check("mem_wdata", mem_wdata, m.data);
                    end
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                    else        mem_rdata = mem_read(mem_addr);
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: CPU responses and cache writes
    // ------------------------------------------------------------------
    initial begin
        sb_t e;
        wr_t w;
        int  lat;
        forever begin
            @(negedge clk);
            if (cache_read && cache_write) check("cache_rd_wr_exclusive", 32'd1, 32'd0);
            if (cpu_done) begin
                if (sb.size() == 0) begin
                    check("unexpected_cpu_done", 32'd1, 32'd0);
                end else begin
                    e   = sb.pop_front();
                    lat = int'(($time - e.t0 + PERIOD/2) / PERIOD);
                    check("cpu_hit", 32'(cpu_hit), 32'(e.hit));
                    check("cpu_rdata", cpu_rdata, e.rdata);
                    check("done_latency", 32'(lat), 32'(e.lat));
                end
            end
            if (cache_write) begin
                if (wq.size() == 0) begin
                    check("unexpected_cache_write", 32'd1, 32'd0);
                end else begin
                    w = wq.pop_front();
                    check("cache_write_data", cache_write_data, w.data);
                    if (w.way >= 0) check("replace_way", 32'(replace_way), 32'(w.way));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    // Issue one request from a negedge with hand-computed expectations.
    // lat == 2 marks a read hit: no memory access and no cache write.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int w, input logic eh, input logic [31:0] ed,
                         input int el, input int eway);
        int  n;
        time t0;
        n = 0;
        while (!cpu_ready && n < 50) begin @(negedge clk); n++; end
        mem_wait  = w;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(posedge clk);
        t0 = $time;
        sb.push_back('{eh, ed, el, t0});
        if (el != 2) begin
            mq.push_back('{we, addr, wdata});
            wq.push_back('{eway, we ? wdata : ed});
        end
        @(negedge clk);
        // Garbage on the CPU inputs while busy must not disturb the request.
        cpu_req   = 1'b0;
        cpu_we    = ~we;
        cpu_addr  = ~addr;
        cpu_wdata = 32'hBAD0_BAD0;
        n = 0;
        while (!cpu_ready && n < 100) begin @(negedge clk); n++; end
        if (!cpu_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int txn0;
        reset_n   = 1'b0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = 32'd0;
        cpu_wdata = 32'd0;
        mem_model[32'h0000_0400] = 32'hDEAD_BEEF;

        repeat (2) @(negedge clk);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd1);
        check("rst_cpu_done", 32'(cpu_done), 32'd0);
        check("rst_cpu_rdata", cpu_rdata, 32'd0);
        check("rst_cpu_hit", 32'(cpu_hit), 32'd0);
        check("rst_cache_read", 32'(cache_read), 32'd0);
        check("rst_cache_write", 32'(cache_write), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_replace_way", 32'(replace_way), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Cold read miss, W=3: done 6 cycles after accept, fill into way 0.
        issue(1'b0, 32'h0000_0400, 32'd0, 3, 1'b0, 32'hDEAD_BEEF, 6, 0);
        // Same address again hits in 2 cycles without touching memory.
        txn0 = mem_txn;
        issue(1'b0, 32'h0000_0400, 32'd0, 1, 1'b1, 32'hDEAD_BEEF, 2, -1);
        check("hit_no_mem_req", 32'(mem_txn), 32'(txn0));
`ifdef CACHE_CTRL_STATS_EN
        check("hit_count", hit_count, 32'd1);
        check("miss_count", miss_count, 32'd1);
`endif
        // Write hit: write-through, rdata 0, latency 3+2.
        issue(1'b1, 32'h0000_0400, 32'h1234_5678, 2, 1'b1, 32'd0, 5, -1);
        issue(1'b0, 32'h0000_0400, 32'd0, 1, 1'b1, 32'h1234_5678, 2, -1);
        // Write hit left set 0's pointer at 1.
        issue(1'b0, 32'h0000_0800, 32'd0, 1, 1'b0, 32'h0800_C0DE, 4, 1);

        // FIFO order in set 0 from a clean reset.
        pulse_reset();
        issue(1'b0, 32'h0000_0400, 32'd0, 1, 1'b0, 32'h1234_5678, 4, 0);
        issue(1'b0, 32'h0000_0800, 32'd0, 2, 1'b0, 32'h0800_C0DE, 5, 1);
        issue(1'b0, 32'h0000_0C00, 32'd0, 1, 1'b0, 32'h0C00_C0DE, 4, 2);
        issue(1'b0, 32'h0000_1000, 32'd0, 1, 1'b0, 32'h1000_C0DE, 4, 3);
        issue(1'b0, 32'h0000_1400, 32'd0, 3, 1'b0, 32'h1400_C0DE, 6, 0);
        issue(1'b0, 32'h0000_0400, 32'd0, 1, 1'b0, 32'h1234_5678, 4, 1);
        issue(1'b0, 32'h0000_1400, 32'd0, 1, 1'b1, 32'h1400_C0DE, 2, -1);

        // Write miss in set 2 allocates way 0; read then hits.
        issue(1'b1, 32'h0000_0840, 32'hCAFE_F00D, 2, 1'b0, 32'd0, 5, 0);
        issue(1'b0, 32'h0000_0840, 32'd0, 1, 1'b1, 32'hCAFE_F00D, 2, -1);

        // Reset while MEM_RD waits: request dropped, no response.
        mem_wait  = 10;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 32'h0000_0480;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        @(negedge clk);
        check("midop_mem_req_high", 32'(mem_req), 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("midop_mem_req_dropped", 32'(mem_req), 32'd0);
        check("midop_cpu_ready", 32'(cpu_ready), 32'd1);
        check("midop_cpu_done", 32'(cpu_done), 32'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_ready", 32'(cpu_ready), 32'd1);
        // Set 0's pointer was 2 before reset; next miss must use way 0.
        issue(1'b0, 32'h0000_0400, 32'd0, 2, 1'b0, 32'h1234_5678, 5, 0);

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("wq_drained", 32'(wq.size()), 32'd0);
        check("mq_drained", 32'(mq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/cache_controller.md
# cache_controller

Sequencing controller for the 4-way set-associative `cache_memory`. It accepts single-word CPU requests, probes the cache, services read misses from main memory, and performs write-through of every write. It owns the replacement decision: a per-set FIFO pointer drives `replace_way`. It sits between the CPU load/store port and the cache/main-memory pair, and is the only master of both.

## Interface
Parameters:
- `NUM_SETS`, default 32: sets in the cache. The set index is `addr[9:5]`.
- `NUM_WAYS`, default 4: ways per set. The FIFO pointer is log2(`NUM_WAYS`) bits wide.

Ports:
- `clk`, input, 1: system clock. Everything is on the rising edge.
- `reset_n`, input, 1: one clock; reset is synchronous and active-low. The top level drives the cache's `reset` with `~reset_n`.
- `cpu_req`, input, 1: request valid.
- `cpu_we`, input, 1: 1 = write, 0 = read.
- `cpu_addr`, input, 32: word address.
- `cpu_wdata`, input, 32: write data.
- `cpu_ready`, output, 1: controller can accept a request (IDLE only).
- `cpu_done`, output, 1: one-cycle response strobe.
- `cpu_rdata`, output, 32: read result. Valid while `cpu_done` is high.
- `cpu_hit`, output, 1: the lookup hit. Valid while `cpu_done` is high.
- `cache_read`, output, 1: cache probe enable.
- `cache_write`, output, 1: cache write enable.
- `cache_address`, output, 32: cache address.
- `cache_write_data`, output, 32: cache write data.
- `cache_read_data`, input, 32: cache read data (combinational).
- `cache_hit`, input, 1: cache hit flag (combinational).
- `replace_way`, output, log2(`NUM_WAYS`): victim way. Equals the FIFO pointer of the current index.
- `mem_req`, output, 1: memory request. Held until acknowledged.
- `mem_we`, output, 1: memory write.
- `mem_addr`, output, 32: memory address.
- `mem_wdata`, output, 32: memory write data.
- `mem_ack`, input, 1: single-cycle acknowledge. On a read, `mem_rdata` is valid in the same cycle.
- `mem_rdata`, input, 32: memory read data.

## Operation
- On the edge where `cpu_req & cpu_ready` is high, the controller latches the request into `req_addr`, `req_we` and `req_wdata`. `cache_address`, `mem_addr` and `mem_wdata` are driven from these latches, never from the `cpu_*` inputs.
- **IDLE**: `cpu_ready`=1. On accept, go to LOOKUP.
- **LOOKUP**: one cycle with `cache_read`=1. Sample `cache_hit` into `hit_q` and `cache_read_data` into `rdata_q`.
  - Read hit: go to RESP.
  - Read miss: go to MEM_RD.
  - Any write: go to MEM_WR.
- **MEM_RD**: `mem_req`=1, `mem_we`=0. On `mem_ack`, capture `mem_rdata` into `rdata_q` and go to FILL.
- **FILL**: one cycle with `cache_write`=1 and `cache_write_data`=`rdata_q`. Advance `fifo_ptr[index]` modulo `NUM_WAYS`. Go to RESP.
- **MEM_WR**: `mem_req`=1, `mem_we`=1. On `mem_ack`, go to UPDATE.
- **UPDATE**: one cycle with `cache_write`=1 and `cache_write_data`=`req_wdata`.
  - If `hit_q`=0 the cache allocates at `replace_way`, and `fifo_ptr[index]` advances.
  - If `hit_q`=1 the pointer is unchanged.
  - Go to RESP.
- **RESP**: `cpu_done`=1, `cpu_rdata`=`rdata_q`, `cpu_hit`=`hit_q`. On writes, `cpu_rdata` is 0. Go to IDLE.
- `cache_read` and `cache_write` are never high in the same cycle. `mem_req` is high only in MEM_RD and MEM_WR.
- The pointer advances only on allocation, so FIFO order per set is 0, 1, 2, 3, 0, …

## Timing
- Reset (`reset_n`=0 at an edge):
  - State goes to IDLE and all `fifo_ptr` entries clear to 0.
  - `cpu_ready`=1 from the first cycle after reset.
  - All other outputs are 0.
- Reset mid-operation: the controller abandons the transaction, drops `mem_req` the cycle after the reset edge, and emits no `cpu_done`.
- Latency, counting the accept edge as E0:
  - Read hit: `cpu_done` is high in the cycle after E1.
  - Read miss: `cpu_done` follows 3 + W cycles after E0, where W is the number of MEM_RD cycles including the ack cycle (W ≥ 1).
  - Write: same as read miss, with W counted in MEM_WR.
- `cpu_ready` is low from LOOKUP through RESP. Back-to-back requests therefore have a minimum spacing of 3 cycles (hit).
- While `mem_req`=1, the memory-side outputs are stable. `mem_ack` is ignored in every other state.
- `cpu_req` may drop or change while `cpu_ready`=0 without effect.

## Configuration
- `CACHE_CTRL_STATS_EN` defined:
  - Adds outputs `hit_count[31:0]` and `miss_count[31:0]`.
  - One of them increments in the RESP cycle of each transaction, chosen by `hit_q`.
  - Both wrap at 2^32 and clear on reset.
- Not defined: the ports and counters are absent and behaviour is otherwise identical.

## Test plan
- Read at `0x0000_0400` after reset, memory returns `0xDEAD_BEEF` after W=3:
  - `mem_req` is high for 3 cycles and `replace_way`=0 in FILL.
  - `cpu_done` occurs 6 cycles after accept, with `cpu_hit`=0 and `cpu_rdata`=`0xDEAD_BEEF`.
- Repeat the read at `0x0000_0400`:
  - `cpu_done` occurs 2 cycles after accept, with `cpu_hit`=1 and `cpu_rdata`=`0xDEAD_BEEF`.
  - `mem_req` never rises.
- Five read misses to index 0, tags 1 through 5:
  - `replace_way` sequence is 0, 1, 2, 3, 0.
  - A read of tag 1 afterwards misses, and a read of tag 5 hits.
- Write `0x1234_5678` to a cached address:
  - Memory write is seen with `mem_we`=1 and matching `mem_addr`/`mem_wdata`.
  - `cpu_hit`=1 and the FIFO pointer is unchanged.
  - A subsequent read hit returns `0x1234_5678`.
- Assert `reset_n`=0 during MEM_RD:
  - `mem_req` is 0 next cycle, `cpu_ready`=1 after release, and no `cpu_done` is emitted.
  - The next miss uses `replace_way`=0.
- With `CACHE_CTRL_STATS_EN` defined, run scenarios 1 and 2: `hit_count`=1 and `miss_count`=1.
